// File: rtl/selector_pkg.sv
// Shared types for the N-input stream selector.
package selector_pkg;

    typedef enum logic {
        SEL_FIXED = 1'b0,
        SEL_RR    = 1'b1
    } sel_mode_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: fixed priority from index 0, or round-robin
// starting just after the previously granted channel.
module rr_arbiter
    import selector_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] last,
    input  sel_mode_t     mode,
    output logic [N-1:0]  gnt_onehot,
    output logic [SW-1:0] gnt_idx,
    output logic          any
);

    logic [SW-1:0] start;
    logic [SW-1:0] idx;
    int unsigned   pos;

    // Walk the channels from the start point with wrap-around; first requester wins.
    always_comb begin
        start      = '0;
        idx        = '0;
        pos        = 0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        if (mode == SEL_RR) begin
            start = (last == SW'(N - 1)) ? '0 : last + SW'(1);
        end
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(start) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = SW'(pos);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/selector_n_stream.sv
// N-input valid/ready stream selector with arbitration and a registered
// output stage that can drain and reload in the same cycle.
module selector_n_stream
    import selector_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned N     = 4,
    localparam int unsigned SW    = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  sel_mode_t               mode,
    input  logic [N-1:0][WIDTH-1:0] d,
    input  logic [N-1:0]            d_valid,
    output logic [N-1:0]            d_ready,
    output logic [WIDTH-1:0]        y,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic [SW-1:0]           y_sel
);

    logic [SW-1:0] last;
    logic [N-1:0]  gnt_onehot;
    logic [SW-1:0] gnt_idx;
    logic          any;
    logic          load_en;

    rr_arbiter #(.N(N)) u_arb (
        .req        (d_valid),
        .last       (last),
        .mode       (mode),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Output register can take a word when empty or when being drained now.
    assign load_en = !y_valid || y_ready;
    assign d_ready = (load_en && rst_n) ? gnt_onehot : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_sel   <= '0;
            last    <= SW'(N - 1);
        end else if (load_en) begin
            if (any) begin
                y       <= d[gnt_idx];
                y_sel   <= gnt_idx;
                y_valid <= 1'b1;
                last    <= gnt_idx;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule
